pattern_loader: RTL and testbench

Serial scan-chain master that loads and reads back one pattern buffer through the `sclk`/`sin`/`sout`/`ssel`/`saddr` interface of the pattern-buffer bank. A host supplies one byte at a time over a valid/ready handshake. The block generates `sclk` from the system clock and shifts the bytes MSB-first into the buffer selected by `saddr`. The bits shifted out on `sout` (the buffer's previous contents) are reassembled into bytes for readback.

---
 rtl/pattern_loader_pkg.sv | 22 ++
 rtl/sclk_divider.sv | 30 +++
 rtl/pattern_loader.sv | 131 +++++++++++++
 tb/tb_pattern_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_loader_pkg.sv
// Shared types and defaults for the pattern-buffer scan-chain loader.
package pattern_loader_pkg;

  localparam int DEFAULT_BUFFER_SIZE  = 22;
  localparam int DEFAULT_BUFFER_WIDTH = 8;
  localparam int DEFAULT_CLK_DIV      = 2;
  localparam int ADDR_WIDTH           = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOW,
    HIGH,
    FINISH
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// Phase counter for one sclk half-period; tick marks the last clk cycle of the phase.
module sclk_divider
  import pattern_loader_pkg::*;
#(
  parameter int clk_div = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = min1_clog2(clk_div);

  logic [CW-1:0] phase_reg;

  assign tick = run && (phase_reg == CW'(clk_div - 1));

  // The count restarts at every phase boundary so LOW and HIGH each get exactly clk_div cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg <= '0;
    end else if (!run || tick) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_reg + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_loader.sv
// Scan-chain master: shifts host bytes MSB-first into a pattern buffer and
// reassembles the displaced contents from sout into readback bytes.
module pattern_loader
  import pattern_loader_pkg::*;
#(
  parameter int buffer_size  = DEFAULT_BUFFER_SIZE,
  parameter int buffer_width = DEFAULT_BUFFER_WIDTH,
  parameter int clk_div      = DEFAULT_CLK_DIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [buffer_width-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [buffer_width-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    sclk,
  output logic                    sin,
  output logic                    ssel,
  output logic [ADDR_WIDTH-1:0]   saddr,
  input  logic                    sout
);

  localparam int BYTE_CW = min1_clog2(buffer_size);
  localparam int BIT_CW  = min1_clog2(buffer_width);

  state_t                  state_reg, state_next;
  logic [BYTE_CW-1:0]      byte_cnt_reg;
  logic [BIT_CW-1:0]       bit_cnt_reg;
  logic [buffer_width-1:0] shift_reg;
  logic [buffer_width-1:0] capture_reg;
  logic                    div_run;
  logic                    tick;
  logic                    last_bit;
  logic                    last_byte;

  assign div_run   = (state_reg == LOW) || (state_reg == HIGH);
  assign last_bit  = (bit_cnt_reg == '0);
  assign last_byte = (byte_cnt_reg == BYTE_CW'(buffer_size - 1));
  // sin comes straight off the shift register, so it only moves at a HIGH->LOW boundary.
  assign sin       = shift_reg[buffer_width-1];

  sclk_divider #(
    .clk_div(clk_div)
  ) u_sclk_divider (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (div_run),
    .tick (tick)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (wr_valid) state_next = LOW;
      LOW:     if (tick) state_next = HIGH;
      HIGH: begin
        if (tick) begin
          if (!last_bit)      state_next = LOW;
          else if (last_byte) state_next = FINISH;
          else                state_next = FETCH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      capture_reg  <= '0;
      saddr        <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      ssel         <= 1'b0;
      sclk         <= 1'b0;
      wr_ready     <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Port strobes are decoded from the next state so they line up with the state register.
      busy      <= (state_next != IDLE);
      ssel      <= (state_next inside {FETCH, LOW, HIGH});
      sclk      <= (state_next == HIGH);
      wr_ready  <= (state_next == FETCH);
      done      <= (state_next == FINISH);
      rd_valid  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            saddr        <= addr;
            byte_cnt_reg <= '0;
          end
        end
        FETCH: begin
          if (wr_valid) begin
            shift_reg   <= wr_data;
            bit_cnt_reg <= BIT_CW'(buffer_width - 1);
          end
        end
        LOW: begin
          if (tick) capture_reg <= {capture_reg[buffer_width-2:0], sout};
        end
        HIGH: begin
          if (tick) begin
            shift_reg <= shift_reg << 1;
            if (!last_bit) begin
              bit_cnt_reg <= bit_cnt_reg - 1'b1;
            end else begin
              rd_valid <= 1'b1;
              rd_data  <= capture_reg;
              if (!last_byte) byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// Randomized scoreboard bench for pattern_loader with a bit-serial buffer-bank model
// and a byte-level reference of every buffer's contents.
module tb_pattern_loader;

  localparam int SIZE     = 22;
  localparam int WIDTH    = 8;
  localparam int DIV      = 2;
  localparam int BITS     = SIZE * WIDTH;
  localparam int DURATION = 2 + SIZE * (1 + 2 * DIV * WIDTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             sin;
  logic             ssel;
  logic [2:0]       saddr;
  logic             sout;

  logic [BITS-1:0]  chain [8];
  logic [7:0]       ref_mem [8][SIZE];
  logic [7:0]       tx_data [SIZE];
  logic [7:0]       exp_q [$];
  logic [7:0]       exp_byte;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_count = 0;
  int done_count = 0;
  int sclk_pulses = 0;

  pattern_loader #(
    .buffer_size (SIZE),
    .buffer_width(WIDTH),
    .clk_div     (DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .addr    (addr),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .sin     (sin),
    .ssel    (ssel),
    .saddr   (saddr),
    .sout    (sout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Buffer bank: index 0 is the chain head driving sout; sin enters at the tail on sclk rise.
  assign sout = chain[saddr][0];
  always @(posedge sclk) begin
    sclk_pulses++;
    if (ssel) chain[saddr] = {sin, chain[saddr][BITS-1:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every readback pulse consumes one expected byte.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      rd_count++;
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rd_data", {24'd0, rd_data}, {24'd0, exp_byte});
      end
    end
    if (done === 1'b1) done_count++;
  end

  task automatic set_buffer(input int a, input logic [7:0] v, input bit rnd);
    logic [7:0] b;
    for (int k = 0; k < SIZE; k++) begin
      b = rnd ? 8'($urandom) : v;
      ref_mem[a][k] = b;
      for (int j = 0; j < WIDTH; j++) chain[a][WIDTH*k+j] = b[7-j];
    end
  endtask

  function automatic logic [7:0] read_bank(input int a, input int k);
    logic [7:0] r;
    for (int j = 0; j < WIDTH; j++) r[7-j] = chain[a][WIDTH*k+j];
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic transfer(input logic [2:0] a, input int stall_byte, input int stall_len,
                          input int rst_byte, input int ign_byte, input string label);
    int  t0;
    int  t_done;
    int  nmis;
    bit  ok;
    bit  stall_ok;
    bit  seen;
    exp_q.delete();
    rd_count    = 0;
    done_count  = 0;
    sclk_pulses = 0;
    @(negedge clk);
    addr  = a;
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    check({label, "_saddr_latch"}, {29'd0, saddr}, {29'd0, a});
    check({label, "_fetch_entry"}, {29'd0, ssel, wr_ready, busy}, 32'b111);
    for (int k = 0; k < SIZE; k++) begin
      if (k == stall_byte) begin
        wr_valid = 1'b0;
        wait_ready(ok);
        stall_ok = ok;
        for (int s = 0; s < stall_len; s++) begin
          if (sclk !== 1'b0 || ssel !== 1'b1 || wr_ready !== 1'b1) stall_ok = 1'b0;
          @(negedge clk);
        end
        check({label, "_stall_hold"}, {31'd0, stall_ok}, 32'd1);
      end
      wr_data  = tx_data[k];
      wr_valid = 1'b1;
      wait_ready(ok);
      if (!ok) begin
        check({label, "_wr_ready_timeout"}, 32'd0, 32'd1);
        wr_valid = 1'b0;
        return;
      end
      exp_q.push_back(ref_mem[a][k]);
      @(negedge clk);
      wr_valid = 1'b0;
      if (k == rst_byte) begin
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check({label, "_reset_drop"}, {28'd0, ssel, sclk, done, busy}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (40) @(negedge clk);
        check({label, "_no_done_after_reset"}, done_count, 32'd0);
        set_buffer(a, 8'h00, 1'b1);
        $display("[TB] transfer %s addr=%0d aborted by reset during byte %0d", label, a, k);
        return;
      end
      if (k == ign_byte) begin
        start = 1'b1;
        addr  = 3'd2;
        @(negedge clk);
        start = 1'b0;
        addr  = a;
      end
    end
    seen = 1'b0;
    t_done = 0;
    for (int i = 0; i < 3 * DURATION; i++) begin
      if (done === 1'b1) begin
        seen   = 1'b1;
        t_done = cyc;
        break;
      end
      @(negedge clk);
    end
    check({label, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({label, "_duration"}, t_done - t0 + 1,
          DURATION + ((stall_byte >= 0 && stall_byte < SIZE) ? stall_len : 0));
    @(negedge clk);
    check({label, "_idle_after_done"}, {30'd0, busy, done}, 32'd0);
    repeat (3) @(negedge clk);
    check({label, "_done_count"}, done_count, 32'd1);
    check({label, "_rd_count"}, rd_count, SIZE);
    check({label, "_sclk_pulses"}, sclk_pulses, BITS);
    check({label, "_saddr_hold"}, {29'd0, saddr}, {29'd0, a});
    check({label, "_scoreboard_empty"}, exp_q.size(), 32'd0);
    for (int k = 0; k < SIZE; k++) ref_mem[a][k] = tx_data[k];
    nmis = 0;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < SIZE; k++)
        if (read_bank(b, k) !== ref_mem[b][k]) nmis++;
    check({label, "_bank_contents"}, nmis, 32'd0);
    $display("[TB] transfer %s addr=%0d done %0d cycles after start", label, a, t_done - t0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    for (int b = 0; b < 8; b++) set_buffer(b, 8'h00, 1'b1);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {25'd0, sclk, sin, ssel, wr_ready, rd_valid, done, busy}, 32'd0);
    check("reset_saddr", {29'd0, saddr}, 32'd0);
    check("reset_rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (ssel !== 1'b0 || busy !== 1'b0 || sclk !== 1'b0) quiet = 1'b0;
    end
    check("idle_quiet", {31'd0, quiet}, 32'd1);

    set_buffer(5, 8'hA5, 1'b0);
    for (int k = 0; k < SIZE; k++) tx_data[k] = 8'(k);
    transfer(3'd5, -1, 0, -1, -1, "full_load");

    for (int k = 0; k < SIZE; k++) tx_data[k] = 8'h3C;
    transfer(3'd1, -1, 0, -1, -1, "rt_load");
    for (int k = 0; k < SIZE; k++) tx_data[k] = 8'hFF;
    transfer(3'd1, -1, 0, -1, -1, "rt_reload");

    for (int k = 0; k < SIZE; k++) tx_data[k] = 8'($urandom);
    transfer(3'd3, 4, 10, -1, -1, "stall");

    for (int k = 0; k < SIZE; k++) tx_data[k] = 8'($urandom);
    transfer(3'd7, -1, 0, 7, -1, "mid_reset");
    for (int k = 0; k < SIZE; k++) tx_data[k] = 8'($urandom);
    transfer(3'd7, -1, 0, -1, -1, "after_reset");

    for (int k = 0; k < SIZE; k++) tx_data[k] = 8'($urandom);
    transfer(3'd6, -1, 0, -1, 9, "ignored_start");

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < SIZE; k++) tx_data[k] = 8'($urandom);
      transfer(3'($urandom_range(0, 7)), int'($urandom_range(0, SIZE - 1)),
               int'($urandom_range(1, 5)), -1, -1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
